sdram_req_gen: RTL and testbench
================================

Name: sdram_req_gen

Overview:
- User-side requester for the SDRAM controller's request/acknowledge interface; it is the opposite end of the `sdram_wr_req`/`sdram_rd_req`/ack/burst handshake.
- Watches the write-FIFO fill level and the read-FIFO free space, and arbitrates between write and read bursts.
- Issues one request at a time to the controller, holding it until acknowledged.
- Generates wrapping SDRAM burst addresses, and emits the FIFO pop/push strobes from the controller acks.

Parameters:
- ADDR_W, 24, SDRAM word-address width (bank+row+col).
- LEN_W, 10, burst-length and FIFO-level width.
- RDF_DEPTH, 512, read-FIFO depth in words.

Ports:
- clk  in  1  system clock (same clock as the SDRAM controller).
- rst  in  1  synchronous, active-high reset.
- sdram_init_done  in  1  controller initialisation complete.
- wr_min_addr / wr_max_addr  in  ADDR_W  write region, inclusive.
- rd_min_addr / rd_max_addr  in  ADDR_W  read region, inclusive.
- wr_len / rd_len  in  LEN_W  burst length in words, 1..512.
- wr_load / rd_load  in  1  pulse: reload the pointer to its min address.
- rd_valid  in  1  read path enabled.
- wrf_use  in  LEN_W  write-FIFO words held.
- rdf_use  in  LEN_W  read-FIFO words held.
- sdram_wr_req / sdram_rd_req  out  1  requests to the controller.
- sdram_wr_ack / sdram_rd_ack  in  1  controller data-phase acks.
- sdram_wr_addr / sdram_rd_addr  out  ADDR_W  burst start address.
- sdram_wr_burst / sdram_rd_burst  out  LEN_W  latched burst length.
- wrf_rdreq  out  1  write-FIFO pop = sdram_wr_ack (combinational).
- rdf_wrreq  out  1  read-FIFO push = sdram_rd_ack (combinational).
- burst_err  out  1  sticky: ack count differed from the burst length.

Behaviour:
- Reset values:
  - state IDLE; both reqs 0.
  - wr_addr = wr_min_addr; rd_addr = rd_min_addr.
  - bursts = 0; burst_err = 0; prio = write.
- Reset mid-burst drops the request the same cycle; no address advance occurs.
- State machine states: IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST.
- Start conditions:
  - wr_go = init_done & wr_len!=0 & wrf_use >= wr_len.
  - rd_go = init_done & rd_valid & rd_len!=0 & (RDF_DEPTH - rdf_use) >= rd_len.
- IDLE arbitration:
  - If both wr_go and rd_go are true, the side indicated by prio wins; prio toggles after every completed burst (round-robin).
  - Otherwise the single true side wins.
  - On entry to *_REQ, latch the length into sdram_*_burst.
- WR_REQ: sdram_wr_req = 1 until the first cycle sdram_wr_ack = 1, then req = 0 and go to WR_BURST. RD_REQ/RD_BURST behave the same way.
- *_BURST:
  - Count ack cycles (LEN_W+1 bits).
  - On the ack falling edge (ack_d=1, ack=0), compare count with the latched burst; on mismatch set burst_err.
  - Then advance the address and return to IDLE. One cycle of IDLE is always inserted between bursts.
- Address advance uses ADDR_W+1-bit arithmetic: next = addr + burst. If next + burst - 1 > max, set addr = min; else addr = next.
  - Example: min=0, max=1023, len=512 gives the sequence 0, 512, 0.
- wr_load/rd_load:
  - Applied immediately if that side is not in *_REQ/*_BURST.
  - Otherwise held pending and applied instead of the advance at burst end.
  - Load and advance in the same cycle: load wins.
- Min/max/len inputs are quasi-static; changes take effect at the next request start.

Optional Feature:
- SDRAM_PINGPONG_EN defined:
  - Address MSB (bank select) is a separate frame bank bit.
  - The write bank toggles when the write pointer wraps.
  - The read bank equals the inverse of the write bank, sampled at read wrap, so reads never overlap the frame being written.
  - Reset sets write bank = 0 and read bank = 1.
- Not defined: addresses are used exactly as computed; no bank toggling.

Decomposition:
- Shared package sdram_req_pkg holds:
  - state enum (IDLE..RD_BURST);
  - ADDR_W/LEN_W defaults;
  - a burst-end helper constant set.
- Natural sub-module: sdram_addr_ptr, instantiated twice (write and read).
  - Holds the pointer, pending load, wrap logic and the optional bank bit.
  - Inputs: min, max, len, load, advance.

Test Plan:
- init_done=0, wrf_use=600, wr_len=256 -> no request. Raise init_done -> sdram_wr_req=1 the next cycle, addr=0, burst=256; hold 256 ack cycles -> wrf_rdreq pulses 256 times, addr becomes 256.
- Write region 0..1023, len=512, three bursts -> start addresses 0, 512, 0; burst_err stays 0.
- wr_go and rd_go both true continuously, rd_valid=1, rdf_use=0, rd_len=128 -> grants alternate W, R, W, R; each request drops on the first ack.
- Give 255 acks for a 256 burst -> burst_err=1 and stays 1 until rst.
- Pulse wr_load during WR_BURST at addr 512 -> next start address is wr_min_addr, not 1024; assert rst mid-burst -> req=0 next cycle, addr=min.
- With SDRAM_PINGPONG_EN: after write wrap, write bank=1; read bank at its next wrap becomes 0.

Source files
------------

// File: rtl/sdram_req_pkg.sv
// Shared definitions for the SDRAM user-side requester.
// Optional feature macro: SDRAM_PINGPONG_EN (frame bank ping-pong in the address MSB).
package sdram_req_pkg;

   localparam int unsigned ADDR_W_DEF    = 24;
   localparam int unsigned LEN_W_DEF     = 10;
   localparam int unsigned RDF_DEPTH_DEF = 512;

   // Requester FSM encoding
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WR_REQ   = 3'd1;
   localparam logic [2:0] ST_WR_BURST = 3'd2;
   localparam logic [2:0] ST_RD_REQ   = 3'd3;
   localparam logic [2:0] ST_RD_BURST = 3'd4;

   // Round-robin priority values
   localparam logic PRIO_WR = 1'b0;
   localparam logic PRIO_RD = 1'b1;

   // A burst ends on the falling edge of the controller ack
   function automatic logic burst_end(input logic ack_d, input logic ack);
      return ack_d & ~ack;
   endfunction

endpackage

// File: rtl/sdram_addr_ptr.sv
// Wrapping SDRAM burst address pointer with deferred reload.
// Optional feature macro: SDRAM_PINGPONG_EN adds a frame bank bit that replaces the address MSB.
module sdram_addr_ptr
   import sdram_req_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned LEN_W  = LEN_W_DEF
`ifdef SDRAM_PINGPONG_EN
   , parameter logic IS_READ = 1'b0
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] min_addr,
   input  logic [ADDR_W-1:0] max_addr,
   input  logic [LEN_W-1:0]  len,
   input  logic              load,
   input  logic              busy,
   input  logic              advance,
   output logic [ADDR_W-1:0] addr
`ifdef SDRAM_PINGPONG_EN
   , input  logic            peer_bank
   , output logic            bank
`endif
);

   localparam int unsigned AW1 = ADDR_W + 1;

   logic [ADDR_W-1:0] ptr_q;
   logic              pend_q;
   logic [ADDR_W:0]   next;
   logic [ADDR_W:0]   last;
   logic              wrap;

   // Candidate next start address and whether its burst would run past max
   always_comb begin
      next = {1'b0, ptr_q} + AW1'(len);
      last = next + AW1'(len) - AW1'(1);
      wrap = last > {1'b0, max_addr};
   end

   // Pointer: load while idle applies now, load while busy waits for burst end
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q  <= min_addr;
         pend_q <= 1'b0;
      end else if (load && !busy) begin
         ptr_q  <= min_addr;
         pend_q <= 1'b0;
      end else if (advance) begin
         pend_q <= 1'b0;
         if (load || pend_q || wrap) begin
            ptr_q <= min_addr;
         end else begin
            ptr_q <= next[ADDR_W-1:0];
         end
      end else if (load) begin
         pend_q <= 1'b1;
      end
   end

`ifdef SDRAM_PINGPONG_EN
   logic bank_q;

   // Write bank flips on wrap; read bank takes the frame not being written
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_q <= IS_READ;
      end else if (advance && !load && !pend_q && wrap) begin
         bank_q <= IS_READ ? ~peer_bank : ~bank_q;
      end
   end

   assign bank = bank_q;
   assign addr = {bank_q, ptr_q[ADDR_W-2:0]};
`else
   assign addr = ptr_q;
`endif

endmodule

// File: rtl/sdram_req_gen.sv
// SDRAM request generator: arbitrates write/read bursts towards the controller.
// Optional feature macro: SDRAM_PINGPONG_EN (frame bank ping-pong between write and read).
module sdram_req_gen
   import sdram_req_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned LEN_W     = LEN_W_DEF,
   parameter int unsigned RDF_DEPTH = RDF_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sdram_init_done,
   input  logic [ADDR_W-1:0] wr_min_addr,
   input  logic [ADDR_W-1:0] wr_max_addr,
   input  logic [ADDR_W-1:0] rd_min_addr,
   input  logic [ADDR_W-1:0] rd_max_addr,
   input  logic [LEN_W-1:0]  wr_len,
   input  logic [LEN_W-1:0]  rd_len,
   input  logic              wr_load,
   input  logic              rd_load,
   input  logic              rd_valid,
   input  logic [LEN_W-1:0]  wrf_use,
   input  logic [LEN_W-1:0]  rdf_use,
   output logic              sdram_wr_req,
   output logic              sdram_rd_req,
   input  logic              sdram_wr_ack,
   input  logic              sdram_rd_ack,
   output logic [ADDR_W-1:0] sdram_wr_addr,
   output logic [ADDR_W-1:0] sdram_rd_addr,
   output logic [LEN_W-1:0]  sdram_wr_burst,
   output logic [LEN_W-1:0]  sdram_rd_burst,
   output logic              wrf_rdreq,
   output logic              rdf_wrreq,
   output logic              burst_err
);

   localparam int unsigned   LW1     = LEN_W + 1;
   localparam logic [LEN_W:0] DEPTH_W = LW1'(RDF_DEPTH);
   localparam logic [LEN_W:0] CNT_ONE = LW1'(1);

   logic [2:0]       state_q, state_d;
   logic             prio_q;
   logic [LEN_W:0]   cnt_q;
   logic             ack_d_q;
   logic             err_q;
   logic [LEN_W-1:0] wr_burst_q, rd_burst_q;

   logic             wr_go, rd_go;
   logic [LEN_W:0]   rd_free;
   logic             wr_side, rd_side;
   logic             cur_ack;
   logic [LEN_W-1:0] cur_burst;
   logic             done;

   // Start conditions, active side and burst-end detection
   always_comb begin
      rd_free   = DEPTH_W - {1'b0, rdf_use};
      wr_go     = sdram_init_done && (wr_len != '0) && (wrf_use >= wr_len);
      rd_go     = sdram_init_done && rd_valid && (rd_len != '0) &&
                  ({1'b0, rdf_use} <= DEPTH_W) && (rd_free >= {1'b0, rd_len});
      wr_side   = (state_q == ST_WR_REQ) || (state_q == ST_WR_BURST);
      rd_side   = (state_q == ST_RD_REQ) || (state_q == ST_RD_BURST);
      cur_ack   = wr_side ? sdram_wr_ack : sdram_rd_ack;
      cur_burst = wr_side ? wr_burst_q : rd_burst_q;
      done      = ((state_q == ST_WR_BURST) || (state_q == ST_RD_BURST)) &&
                  burst_end(ack_d_q, cur_ack);
   end

   // Next state: round-robin when both sides are ready
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (wr_go && (!rd_go || prio_q == PRIO_WR)) begin
               state_d = ST_WR_REQ;
            end else if (rd_go) begin
               state_d = ST_RD_REQ;
            end
         end
         ST_WR_REQ:   if (sdram_wr_ack) state_d = ST_WR_BURST;
         ST_RD_REQ:   if (sdram_rd_ack) state_d = ST_RD_BURST;
         ST_WR_BURST: if (done) state_d = ST_IDLE;
         ST_RD_BURST: if (done) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // State, ack counting, burst latch and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         prio_q     <= PRIO_WR;
         cnt_q      <= '0;
         ack_d_q    <= 1'b0;
         err_q      <= 1'b0;
         wr_burst_q <= '0;
         rd_burst_q <= '0;
      end else begin
         state_q <= state_d;
         ack_d_q <= cur_ack;
         // Only the first ack is seen in *_REQ, so counting any active ack is exact
         if (state_q == ST_IDLE) begin
            cnt_q <= '0;
         end else if (cur_ack) begin
            cnt_q <= cnt_q + CNT_ONE;
         end
         if (state_q == ST_IDLE && state_d == ST_WR_REQ) wr_burst_q <= wr_len;
         if (state_q == ST_IDLE && state_d == ST_RD_REQ) rd_burst_q <= rd_len;
         if (done) begin
            prio_q <= ~prio_q;
            if (cnt_q != {1'b0, cur_burst}) err_q <= 1'b1;
         end
      end
   end

`ifdef SDRAM_PINGPONG_EN
   logic wr_bank, rd_bank;
`endif

   sdram_addr_ptr #(
      .ADDR_W   (ADDR_W),
      .LEN_W    (LEN_W)
`ifdef SDRAM_PINGPONG_EN
      , .IS_READ(1'b0)
`endif
   ) u_wr_ptr (
      .clk      (clk),
      .rst      (rst),
      .min_addr (wr_min_addr),
      .max_addr (wr_max_addr),
      .len      (wr_burst_q),
      .load     (wr_load),
      .busy     (wr_side),
      .advance  (done && state_q == ST_WR_BURST),
      .addr     (sdram_wr_addr)
`ifdef SDRAM_PINGPONG_EN
      , .peer_bank(rd_bank)
      , .bank     (wr_bank)
`endif
   );

   sdram_addr_ptr #(
      .ADDR_W   (ADDR_W),
      .LEN_W    (LEN_W)
`ifdef SDRAM_PINGPONG_EN
      , .IS_READ(1'b1)
`endif
   ) u_rd_ptr (
      .clk      (clk),
      .rst      (rst),
      .min_addr (rd_min_addr),
      .max_addr (rd_max_addr),
      .len      (rd_burst_q),
      .load     (rd_load),
      .busy     (rd_side),
      .advance  (done && state_q == ST_RD_BURST),
      .addr     (sdram_rd_addr)
`ifdef SDRAM_PINGPONG_EN
      , .peer_bank(wr_bank)
      , .bank     (rd_bank)
`endif
   );

   assign sdram_wr_req   = (state_q == ST_WR_REQ);
   assign sdram_rd_req   = (state_q == ST_RD_REQ);
   assign sdram_wr_burst = wr_burst_q;
   assign sdram_rd_burst = rd_burst_q;
   assign wrf_rdreq      = sdram_wr_ack;
   assign rdf_wrreq      = sdram_rd_ack;
   assign burst_err      = err_q;

endmodule

// File: tb/tb_sdram_req_gen.sv
// Randomised scoreboard bench for sdram_req_gen with a behavioural pointer/arbiter model.
`timescale 1ns/1ps
module tb_sdram_req_gen;

   localparam int unsigned AW    = 24;
   localparam int unsigned LW    = 10;
   localparam int unsigned DEPTH = 512;

   logic          clk = 1'b0;
   logic          rst;
   logic          sdram_init_done;
   logic [AW-1:0] wr_min_addr, wr_max_addr, rd_min_addr, rd_max_addr;
   logic [LW-1:0] wr_len, rd_len;
   logic          wr_load, rd_load, rd_valid;
   logic [LW-1:0] wrf_use, rdf_use;
   logic          sdram_wr_req, sdram_rd_req;
   logic          sdram_wr_ack, sdram_rd_ack;
   logic [AW-1:0] sdram_wr_addr, sdram_rd_addr;
   logic [LW-1:0] sdram_wr_burst, sdram_rd_burst;
   logic          wrf_rdreq, rdf_wrreq, burst_err;

   sdram_req_gen dut (
      .clk             (clk),
      .rst             (rst),
      .sdram_init_done (sdram_init_done),
      .wr_min_addr     (wr_min_addr),
      .wr_max_addr     (wr_max_addr),
      .rd_min_addr     (rd_min_addr),
      .rd_max_addr     (rd_max_addr),
      .wr_len          (wr_len),
      .rd_len          (rd_len),
      .wr_load         (wr_load),
      .rd_load         (rd_load),
      .rd_valid        (rd_valid),
      .wrf_use         (wrf_use),
      .rdf_use         (rdf_use),
      .sdram_wr_req    (sdram_wr_req),
      .sdram_rd_req    (sdram_rd_req),
      .sdram_wr_ack    (sdram_wr_ack),
      .sdram_rd_ack    (sdram_rd_ack),
      .sdram_wr_addr   (sdram_wr_addr),
      .sdram_rd_addr   (sdram_rd_addr),
      .sdram_wr_burst  (sdram_wr_burst),
      .sdram_rd_burst  (sdram_rd_burst),
      .wrf_rdreq       (wrf_rdreq),
      .rdf_wrreq       (rdf_wrreq),
      .burst_err       (burst_err)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      logic          side;   // 0 write, 1 read
      logic [AW-1:0] addr;
      logic [LW-1:0] len;
   } exp_t;
   exp_t exp_q[$];

   // Reference model state
   logic [AW-1:0] m_wr_ptr, m_rd_ptr;
   logic          m_prio, m_err;
`ifdef SDRAM_PINGPONG_EN
   logic          m_wr_bank, m_rd_bank;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] exp_addr(input logic side);
      logic [AW-1:0] p;
      p = side ? m_rd_ptr : m_wr_ptr;
`ifdef SDRAM_PINGPONG_EN
      p[AW-1] = side ? m_rd_bank : m_wr_bank;
`endif
      return p;
   endfunction

   task automatic model_reset();
      m_wr_ptr = wr_min_addr;
      m_rd_ptr = rd_min_addr;
      m_prio   = 1'b0;
      m_err    = 1'b0;
`ifdef SDRAM_PINGPONG_EN
      m_wr_bank = 1'b0;
      m_rd_bank = 1'b1;
`endif
   endtask

   // Burst completion: error check, reload or wrapping advance, round-robin flip
   task automatic model_end(input logic side, input int len, input int nacks, input logic loaded);
      longint p, mn, mx, nx;
      p  = side ? m_rd_ptr : m_wr_ptr;
      mn = side ? rd_min_addr : wr_min_addr;
      mx = side ? rd_max_addr : wr_max_addr;
      if (nacks != len) m_err = 1'b1;
      nx = p + len;
      if (loaded) begin
         p = mn;
      end else if (nx + len - 1 > mx) begin
         p = mn;
`ifdef SDRAM_PINGPONG_EN
         if (side) m_rd_bank = ~m_wr_bank;
         else      m_wr_bank = ~m_wr_bank;
`endif
      end else begin
         p = nx;
      end
      if (side) m_rd_ptr = AW'(p);
      else      m_wr_ptr = AW'(p);
      m_prio = ~m_prio;
   endtask

   task automatic idle_load(input logic do_wr, input logic do_rd);
      wr_load = do_wr;
      rd_load = do_rd;
      @(negedge clk);
      wr_load = 1'b0;
      rd_load = 1'b0;
      if (do_wr) m_wr_ptr = wr_min_addr;
      if (do_rd) m_rd_ptr = rd_min_addr;
   endtask

   // One burst: mode bit0 = write ready, bit1 = read ready; delta skews the ack count
   task automatic txn(input int mode, input logic [LW-1:0] wl, input logic [LW-1:0] rl,
                      input int delta, input logic mid_load);
      logic side;
      int   len, nacks, cnt, waited;
      exp_t e;
      wr_len = wl;
      rd_len = rl;
      if ((mode & 1) != 0) wrf_use = LW'(int'(wl) + $urandom_range(0, 1023 - int'(wl)));
      else                 wrf_use = wl - LW'(1);
      if ((mode & 2) != 0) begin
         rd_valid = 1'b1;
         rdf_use  = LW'($urandom_range(0, DEPTH - int'(rl)));
      end else begin
         rd_valid = 1'($urandom_range(0, 1));
         rdf_use  = LW'(DEPTH - int'(rl) + 1);
      end
      side   = (mode == 3) ? m_prio : (mode == 2);
      len    = side ? int'(rl) : int'(wl);
      e.side = side;
      e.addr = exp_addr(side);
      e.len  = side ? rl : wl;
      exp_q.push_back(e);
      nacks = len + delta;
      if (nacks < 1) nacks = 1;

      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!(sdram_wr_req || sdram_rd_req) && waited < 20);
      wrf_use  = '0;
      rd_valid = 1'b0;
      if (!(sdram_wr_req || sdram_rd_req)) begin
         check("req_timeout", 32'd0, 32'd1);
         exp_q.delete();
         return;
      end

      repeat ($urandom_range(0, 3)) @(negedge clk);
      cnt = 0;
      for (int i = 0; i < nacks; i++) begin
         if (side) sdram_rd_ack = 1'b1;
         else      sdram_wr_ack = 1'b1;
         if (mid_load && i == nacks / 2) begin
            if (side) rd_load = 1'b1;
            else      wr_load = 1'b1;
         end
         #1;
         cnt += side ? int'(rdf_wrreq) : int'(wrf_rdreq);
         @(negedge clk);
         wr_load = 1'b0;
         rd_load = 1'b0;
         if (i == 0) check("req_drop_on_ack", side ? sdram_rd_req : sdram_wr_req, 32'd0);
      end
      sdram_wr_ack = 1'b0;
      sdram_rd_ack = 1'b0;
      check("fifo_strobes", cnt, nacks);
      model_end(side, len, nacks, mid_load);
      repeat (2) @(negedge clk);
      check("burst_err", burst_err, m_err);
      check("idle_after_burst", {sdram_wr_req, sdram_rd_req}, 32'd0);
   endtask

   // Monitor: every new request is matched against the oldest expected grant
   initial begin
      logic wp, rp;
      exp_t e;
      wp = 1'b0;
      rp = 1'b0;
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            if (sdram_wr_req && sdram_rd_req) check("single_request", 32'd1, 32'd0);
            if ((sdram_wr_req && !wp) || (sdram_rd_req && !rp)) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_request", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("grant_side", sdram_rd_req, e.side);
                  check("start_addr", e.side ? sdram_rd_addr : sdram_wr_addr, e.addr);
                  check("burst_len", e.side ? sdram_rd_burst : sdram_wr_burst, e.len);
               end
            end
         end
         wp = sdram_wr_req;
         rp = sdram_rd_req;
      end
   end

   initial begin
      int mode;
      logic [LW-1:0] wl, rl;
      exp_t e;
      rst = 1'b1;
      sdram_init_done = 1'b0;
      wr_min_addr = 24'd0;    wr_max_addr = 24'd1023;
      rd_min_addr = 24'd4096; rd_max_addr = 24'd8191;
      wr_len = 10'd256; rd_len = 10'd128;
      wr_load = 1'b0; rd_load = 1'b0; rd_valid = 1'b0;
      wrf_use = 10'd600; rdf_use = '0;
      sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      check("rst_reqs", {sdram_wr_req, sdram_rd_req}, 32'd0);
      check("rst_wr_addr", sdram_wr_addr, exp_addr(1'b0));
      check("rst_rd_addr", sdram_rd_addr, exp_addr(1'b1));
      check("rst_bursts", {sdram_wr_burst, sdram_rd_burst}, 32'd0);
      check("rst_err", burst_err, 32'd0);

      // No request before controller initialisation completes
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("no_req_before_init", sdram_wr_req, 32'd0);
      end
      sdram_init_done = 1'b1;

      txn(1, 10'd256, 10'd128, 0, 1'b0);
      txn(1, 10'd256, 10'd128, 0, 1'b0);         // starts at 256
      idle_load(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) txn(1, 10'd512, 10'd128, 0, 1'b0);  // 0, 512, 0

      // Both sides ready: grants alternate
      for (int i = 0; i < 4; i++) txn(3, 10'd64, 10'd128, 0, 1'b0);
      for (int i = 0; i < 3; i++) txn(2, 10'd64, 10'd200, 0, 1'b0);

      // Load during a burst at 512 returns to min instead of 1024
      wr_max_addr = 24'd4095;
      idle_load(1'b1, 1'b0);
      txn(1, 10'd512, 10'd1, 0, 1'b0);
      txn(1, 10'd512, 10'd1, 0, 1'b1);
      txn(1, 10'd512, 10'd1, 0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            wr_min_addr = AW'($urandom_range(0, 2048));
            wr_max_addr = wr_min_addr + AW'($urandom_range(0, 2048));
            rd_min_addr = AW'($urandom_range(4096, 6000));
            rd_max_addr = rd_min_addr + AW'($urandom_range(0, 2048));
         end
         if ($urandom_range(0, 9) == 0) idle_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         mode = $urandom_range(1, 3);
         wl = ($urandom_range(0, 7) == 0) ? 10'd512 : LW'($urandom_range(1, 40));
         rl = ($urandom_range(0, 7) == 0) ? 10'd512 : LW'($urandom_range(1, 40));
         txn(mode, wl, rl, 0, ($urandom_range(0, 4) == 0));
      end

      // Short burst: sticky error
      txn(1, 10'd256, 10'd1, -1, 1'b0);
      txn(2, 10'd1, 10'd16, 0, 1'b0);
      check("err_sticky", burst_err, 32'd1);

      // Reset in the middle of a write burst
      wr_min_addr = 24'd100; wr_max_addr = 24'd5000;
      wr_len = 10'd64; wrf_use = 10'd100;
      e.side = 1'b0; e.addr = exp_addr(1'b0); e.len = 10'd64;
      exp_q.push_back(e);
      for (int i = 0; i < 20 && !sdram_wr_req; i++) @(negedge clk);
      wrf_use = '0;
      check("mid_rst_req_seen", sdram_wr_req, 32'd1);
      for (int i = 0; i < 10; i++) begin
         sdram_wr_ack = 1'b1;
         @(negedge clk);
      end
      sdram_wr_ack = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      model_reset();
      exp_q.delete();
      check("rst_mid_req", sdram_wr_req, 32'd0);
      check("rst_mid_addr", sdram_wr_addr, exp_addr(1'b0));
      check("rst_mid_err", burst_err, 32'd0);
      check("rst_mid_burst", sdram_wr_burst, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      txn(1, 10'd32, 10'd1, 0, 1'b0);
      txn(3, 10'd32, 10'd32, 0, 1'b0);
      txn(3, 10'd32, 10'd32, 0, 1'b0);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
